// File: rtl/uart_pkg.sv
// Shared UART state encoding and timing/parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

  // Cycles per bit: base at sel=3, doubling for each step down.
  function automatic int unsigned bit_period(input int unsigned base, input logic [1:0] sel);
    return base << (2'd3 - sel);
  endfunction

  // Callers zero-extend narrower words; the extra zeros leave the XOR unchanged.
  function automatic logic parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; period is captured on load and auto-reloads.
module uart_bit_timer #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] period,
  output logic         half_tick,
  output logic         full_tick
);

  logic [W-1:0] per_q;
  logic [W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      per_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      per_q <= period;
      cnt   <= period - W'(1);
    end else if (cnt == '0) begin
      cnt   <= per_q - W'(1);
    end else begin
      cnt   <= cnt - W'(1);
    end
  end

  // Full tick ends each period; half tick lands floor(P/2) cycles before it.
  assign full_tick = (cnt == '0);
  assign half_tick = (cnt == (per_q >> 1));

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART: independent TX and RX FSMs timed from the system clock.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BASE_DIV   = 26,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [1:0]        baud_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_par_err
);

  localparam int   CNT_W = $clog2(BASE_DIV * 8 + 1);
  localparam logic ODD   = (PARITY_ODD != 0);

  logic [CNT_W-1:0] per_sel;
  assign per_sel = CNT_W'(bit_period(BASE_DIV, baud_sel));

  // ---------------- TX ----------------
  uart_state_e       tx_st, tx_st_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic [3:0]        tx_bits, tx_bits_n;
  logic              tx_par, tx_par_n, tx_q, tx_d;
  logic              tx_tick, tx_half_unused, tx_accept, tx_last;

  assign tx_accept = (tx_st == IDLE) && tx_start;

  uart_bit_timer #(.W(CNT_W)) u_tx_timer (
    .clk_in    (clk_in),
    .rst       (rst),
    .load      (tx_accept),
    .period    (per_sel),
    .half_tick (tx_half_unused),
    .full_tick (tx_tick)
  );

  always_comb begin
    tx_st_n   = tx_st;
    tx_sh_n   = tx_sh;
    tx_bits_n = tx_bits;
    tx_par_n  = tx_par;
    tx_last   = 1'b0;
    case (tx_st)
      IDLE: if (tx_start) begin
        tx_st_n   = START;
        tx_sh_n   = tx_data;
        tx_par_n  = parity(9'(tx_data), ODD);
        tx_bits_n = '0;
      end
      START: if (tx_tick) tx_st_n = DATA;
      DATA: if (tx_tick) begin
        tx_sh_n = tx_sh >> 1;
        if (tx_bits == 4'(DATA_W - 1)) begin
          tx_bits_n = '0;
          tx_st_n   = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          tx_bits_n = tx_bits + 4'd1;
        end
      end
      PARITY: if (tx_tick) tx_st_n = STOP;
      STOP: if (tx_tick) begin
        if (tx_bits == 4'(STOP_BITS - 1)) begin
          tx_st_n = IDLE;
          tx_last = 1'b1;
        end else begin
          tx_bits_n = tx_bits + 4'd1;
        end
      end
      default: tx_st_n = IDLE;
    endcase
    // Line level is registered from the next state so tx never glitches.
    case (tx_st_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_sh_n[0];
      PARITY:  tx_d = tx_par_n;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tx_st   <= IDLE;
      tx_sh   <= '0;
      tx_bits <= '0;
      tx_par  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      tx_st   <= tx_st_n;
      tx_sh   <= tx_sh_n;
      tx_bits <= tx_bits_n;
      tx_par  <= tx_par_n;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_st != IDLE);
  assign tx_done = tx_last;

  // ---------------- RX ----------------
  uart_state_e       rx_st, rx_st_n;
  logic [DATA_W-1:0] rx_sh, rx_sh_n, rx_data_n;
  logic [3:0]        rx_bits, rx_bits_n;
  logic [1:0]        rx_pipe;
  logic              rx_s, rx_prev, rx_fall, rx_load, rx_tick, rx_half;
  logic              rx_pbit, rx_pbit_n, rx_valid_n, rx_fe_n, rx_pe_n;

  assign rx_s    = rx_pipe[1];
  assign rx_fall = rx_prev && !rx_s;
  // Restarting the timer at mid-start aligns later full ticks to bit centres.
  assign rx_load = ((rx_st == IDLE) && rx_fall) || ((rx_st == START) && rx_half);

  uart_bit_timer #(.W(CNT_W)) u_rx_timer (
    .clk_in    (clk_in),
    .rst       (rst),
    .load      (rx_load),
    .period    (per_sel),
    .half_tick (rx_half),
    .full_tick (rx_tick)
  );

  always_comb begin
    rx_st_n    = rx_st;
    rx_sh_n    = rx_sh;
    rx_bits_n  = rx_bits;
    rx_pbit_n  = rx_pbit;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_fe_n    = rx_frame_err;
    rx_pe_n    = rx_par_err;
    case (rx_st)
      IDLE:  if (rx_fall) rx_st_n = START;
      START: if (rx_half) begin
        rx_st_n   = rx_s ? IDLE : DATA;
        rx_bits_n = '0;
      end
      DATA: if (rx_tick) begin
        rx_sh_n = {rx_s, rx_sh[DATA_W-1:1]};
        if (rx_bits == 4'(DATA_W - 1)) begin
          rx_bits_n = '0;
          rx_st_n   = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          rx_bits_n = rx_bits + 4'd1;
        end
      end
      PARITY: if (rx_tick) begin
        rx_pbit_n = rx_s;
        rx_st_n   = STOP;
      end
      STOP: if (rx_tick) begin
        rx_st_n    = IDLE;
        rx_valid_n = 1'b1;
        rx_data_n  = rx_sh;
        rx_fe_n    = !rx_s;
        rx_pe_n    = (PARITY_EN != 0) && (rx_pbit != parity(9'(rx_sh), ODD));
      end
      default: rx_st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rx_pipe      <= 2'b11;
      rx_prev      <= 1'b1;
      rx_st        <= IDLE;
      rx_sh        <= '0;
      rx_bits      <= '0;
      rx_pbit      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_par_err   <= 1'b0;
    end else begin
      rx_pipe      <= {rx_pipe[0], rx};
      rx_prev      <= rx_s;
      rx_st        <= rx_st_n;
      rx_sh        <= rx_sh_n;
      rx_bits      <= rx_bits_n;
      rx_pbit      <= rx_pbit_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      rx_frame_err <= rx_fe_n;
      rx_par_err   <= rx_pe_n;
    end
  end

endmodule
